// File: rtl/pipe_stage_skid_reg.sv
// Generic inter-stage pipeline register with valid/ready handshake, flush and optional 2-entry skid.
// Latency: 1 cycle from in_fire to out_valid; 1 entry/cycle sustained when out_ready=1.
// Backpressure: SKID_EN=1 gives a registered in_ready (absorbs one extra entry); SKID_EN=0 gives a combinational in_ready.
module pipe_stage_skid_reg #(
  parameter int              DATA_W      = 32,
  parameter int              CTRL_W      = 8,
  parameter logic [CTRL_W-1:0] CTRL_BUBBLE = '0,
  parameter bit              SKID_EN     = 1'b1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy
);

  logic              in_fire;
  logic              out_fire;
  logic              main_valid;
  logic              main_valid_nxt;
  logic [DATA_W-1:0] main_data;
  logic [DATA_W-1:0] main_data_nxt;
  logic [CTRL_W-1:0] main_ctrl;
  logic [CTRL_W-1:0] main_ctrl_nxt;
  logic              skid_valid;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_valid & out_ready;

  generate
    if (SKID_EN) begin : g_skid
      logic              skid_valid_q;
      logic              skid_valid_nxt;
      logic              skid_load;
      logic [DATA_W-1:0] skid_data_q;
      logic [CTRL_W-1:0] skid_ctrl_q;
      logic              in_ready_q;

      // Next-state: drain main (refilled from skid if held), then place a new entry in the first free slot
      always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        main_ctrl_nxt  = main_ctrl;
        skid_valid_nxt = skid_valid_q;
        skid_load      = 1'b0;
        if (out_fire) begin
          if (skid_valid_q) begin
            main_data_nxt  = skid_data_q;
            main_ctrl_nxt  = skid_ctrl_q;
            skid_valid_nxt = 1'b0;
          end else begin
            main_valid_nxt = 1'b0;
          end
        end
        if (in_fire) begin
          if (!main_valid_nxt) begin
            main_valid_nxt = 1'b1;
            main_data_nxt  = in_data;
            main_ctrl_nxt  = in_ctrl;
          end else begin
            skid_valid_nxt = 1'b1;
            skid_load      = 1'b1;
          end
        end
      end

      // Skid valid and registered ready; ready drops only when both slots will be occupied
      always_ff @(posedge clk) begin
        if (reset || flush) begin
          skid_valid_q <= 1'b0;
          in_ready_q   <= 1'b1;
        end else begin
          skid_valid_q <= skid_valid_nxt;
          in_ready_q   <= !(main_valid_nxt && skid_valid_nxt);
        end
      end

      // Skid payload needs no reset: it is never observed while skid_valid_q is low
      always_ff @(posedge clk) begin
        if (skid_load) begin
          skid_data_q <= in_data;
          skid_ctrl_q <= in_ctrl;
        end
      end

      assign in_ready   = in_ready_q;
      assign skid_valid = skid_valid_q;
    end else begin : g_noskid
      // Next-state: a new entry replaces the current one; a lone out_fire empties the stage
      always_comb begin
        main_valid_nxt = main_valid;
        main_data_nxt  = main_data;
        main_ctrl_nxt  = main_ctrl;
        if (in_fire) begin
          main_valid_nxt = 1'b1;
          main_data_nxt  = in_data;
          main_ctrl_nxt  = in_ctrl;
        end else if (out_fire) begin
          main_valid_nxt = 1'b0;
        end
      end

      assign in_ready   = !main_valid | out_ready;
      assign skid_valid = 1'b0;
    end
  endgenerate

  // Main (output) register; reset and flush both squash to an inert bubble
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      main_valid <= 1'b0;
      main_data  <= '0;
      main_ctrl  <= CTRL_BUBBLE;
    end else begin
      main_valid <= main_valid_nxt;
      main_data  <= main_data_nxt;
      main_ctrl  <= main_ctrl_nxt;
    end
  end

  assign out_valid = main_valid;
  assign out_data  = main_data;
  assign out_ctrl  = main_valid ? main_ctrl : CTRL_BUBBLE;
  assign occupancy = {1'b0, main_valid} + {1'b0, skid_valid};

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
module tb_pipe_stage_skid_reg;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // skid instance (s_) and single-entry instance (n_)
  logic        s_reset = 1'b1, s_flush = 1'b0, s_in_valid = 1'b0, s_out_ready = 1'b0;
  logic        s_in_ready, s_out_valid;
  logic [31:0] s_in_data = '0, s_out_data;
  logic [7:0]  s_in_ctrl = '0, s_out_ctrl;
  logic [1:0]  s_occ;

  logic        n_reset = 1'b1, n_flush = 1'b0, n_in_valid = 1'b0, n_out_ready = 1'b0;
  logic        n_in_ready, n_out_valid;
  logic [31:0] n_in_data = '0, n_out_data;
  logic [7:0]  n_in_ctrl = '0, n_out_ctrl;
  logic [1:0]  n_occ;

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(8'h00), .SKID_EN(1'b1)) dut (
    .clk(clk), .reset(s_reset), .flush(s_flush),
    .in_valid(s_in_valid), .in_ready(s_in_ready), .in_data(s_in_data), .in_ctrl(s_in_ctrl),
    .out_valid(s_out_valid), .out_ready(s_out_ready), .out_data(s_out_data), .out_ctrl(s_out_ctrl),
    .occupancy(s_occ));

  pipe_stage_skid_reg #(.DATA_W(32), .CTRL_W(8), .CTRL_BUBBLE(8'h00), .SKID_EN(1'b0)) dut0 (
    .clk(clk), .reset(n_reset), .flush(n_flush),
    .in_valid(n_in_valid), .in_ready(n_in_ready), .in_data(n_in_data), .in_ctrl(n_in_ctrl),
    .out_valid(n_out_valid), .out_ready(n_out_ready), .out_data(n_out_data), .out_ctrl(n_out_ctrl),
    .occupancy(n_occ));

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, want %h", nm, act, exp);
    end
  endtask

  // Reference model: a bounded queue per instance (capacity 2 with registered ready, or 1 with pass-through ready)
  logic [39:0] qs[$];
  logic [39:0] qn[$];
  bit          rs = 1'b1;
  bit          en_s = 1'b0, en_n = 1'b0;
  logic [31:0] recv_s[$];
  logic [31:0] recv_n[$];

  always @(posedge clk) begin
    bit pop_s, push_s, pop_n, push_n, rn;
    if (s_reset) begin
      qs.delete(); rs = 1'b1; en_s = 1'b1;
    end else if (s_flush) begin
      qs.delete(); rs = 1'b1;
    end else begin
      pop_s  = (qs.size() > 0) && s_out_ready;
      push_s = s_in_valid && rs;
      if (pop_s) void'(qs.pop_front());
      if (push_s) qs.push_back({s_in_ctrl, s_in_data});
      rs = (qs.size() < 2);
    end
    if (n_reset) begin
      qn.delete(); en_n = 1'b1;
    end else if (n_flush) begin
      qn.delete();
    end else begin
      rn     = (qn.size() == 0) || n_out_ready;
      pop_n  = (qn.size() > 0) && n_out_ready;
      push_n = n_in_valid && rn;
      if (pop_n) void'(qn.pop_front());
      if (push_n) qn.push_back({n_in_ctrl, n_in_data});
    end
  end

  // Compare every cycle, mid-period, and log delivered entries
  always @(negedge clk) begin
    bit ev;
    if (en_s) begin
      ev = qs.size() > 0;
      chk("s_out_valid", 64'(s_out_valid), 64'(ev));
      chk("s_out_ctrl", 64'(s_out_ctrl), ev ? 64'(qs[0][39:32]) : 64'h00);
      if (ev) chk("s_out_data", 64'(s_out_data), 64'(qs[0][31:0]));
      chk("s_occupancy", 64'(s_occ), 64'(qs.size()));
      chk("s_in_ready", 64'(s_in_ready), 64'(rs));
      if (s_out_valid && s_out_ready) recv_s.push_back(s_out_data);
    end
    if (en_n) begin
      ev = qn.size() > 0;
      chk("n_out_valid", 64'(n_out_valid), 64'(ev));
      chk("n_out_ctrl", 64'(n_out_ctrl), ev ? 64'(qn[0][39:32]) : 64'h00);
      if (ev) chk("n_out_data", 64'(n_out_data), 64'(qn[0][31:0]));
      chk("n_occupancy", 64'(n_occ), 64'(qn.size()));
      chk("n_in_ready", 64'(n_in_ready), 64'((qn.size() == 0) || n_out_ready));
      if (n_out_valid && n_out_ready) recv_n.push_back(n_out_data);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  bit done_s = 1'b0, done_n = 1'b0;

  // Skid instance: directed scenarios with hand-computed expectations
  initial begin
    logic [31:0] exp_s[$];
    int k;
    bit fire;
    tick(); tick();
    s_reset = 1'b0;
    chk("rst_occ", 64'(s_occ), 64'd0);
    chk("rst_out_valid", 64'(s_out_valid), 64'd0);
    chk("rst_out_data", 64'(s_out_data), 64'd0);
    chk("rst_out_ctrl", 64'(s_out_ctrl), 64'h00);
    chk("rst_in_ready", 64'(s_in_ready), 64'd1);

    // stream three entries at full rate
    s_out_ready = 1'b1; s_in_valid = 1'b1; s_in_data = 32'h1000; s_in_ctrl = 8'h01;
    tick();
    chk("stream_lat_valid", 64'(s_out_valid), 64'd1);
    chk("stream_d0", 64'(s_out_data), 64'h1000);
    chk("stream_occ0", 64'(s_occ), 64'd1);
    s_in_data = 32'h1004; s_in_ctrl = 8'h02;
    tick();
    chk("stream_d1", 64'(s_out_data), 64'h1004);
    chk("stream_occ1", 64'(s_occ), 64'd1);
    s_in_data = 32'h1008; s_in_ctrl = 8'h03;
    tick();
    chk("stream_d2", 64'(s_out_data), 64'h1008);
    chk("stream_occ2", 64'(s_occ), 64'd1);
    s_in_valid = 1'b0;
    tick();
    chk("stream_drained", 64'(s_out_valid), 64'd0);

    // backpressure fill into the skid slot
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'hAAAA0001; s_in_ctrl = 8'hA1;
    tick();
    chk("bp_occ1", 64'(s_occ), 64'd1);
    s_in_data = 32'hBBBB0002; s_in_ctrl = 8'hB2;
    tick();
    chk("bp_occ2", 64'(s_occ), 64'd2);
    chk("bp_in_ready", 64'(s_in_ready), 64'd0);
    chk("bp_hold_a", 64'(s_out_data), 64'hAAAA0001);
    s_in_valid = 1'b0;
    tick();
    chk("bp_stable_d", 64'(s_out_data), 64'hAAAA0001);
    chk("bp_stable_c", 64'(s_out_ctrl), 64'hA1);
    s_out_ready = 1'b1;
    tick();
    chk("bp_then_b", 64'(s_out_data), 64'hBBBB0002);
    chk("bp_ready_back", 64'(s_in_ready), 64'd1);
    chk("bp_occ_after", 64'(s_occ), 64'd1);
    tick();
    chk("bp_empty", 64'(s_occ), 64'd0);

    // bubbles: idle input with a non-inert ctrl value present on the bus
    s_in_ctrl = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("bubble_valid", 64'(s_out_valid), 64'd0);
      chk("bubble_ctrl", 64'(s_out_ctrl), 64'h00);
    end

    // flush a full stage while 0xDEAD is offered
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h11; s_in_ctrl = 8'h03;
    tick();
    s_in_data = 32'h22; s_in_ctrl = 8'h04;
    tick();
    chk("fl_full", 64'(s_occ), 64'd2);
    s_flush = 1'b1; s_in_data = 32'hDEAD; s_in_ctrl = 8'h05;
    tick();
    s_flush = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    chk("fl_occ", 64'(s_occ), 64'd0);
    chk("fl_valid", 64'(s_out_valid), 64'd0);
    chk("fl_ctrl", 64'(s_out_ctrl), 64'h00);
    chk("fl_data", 64'(s_out_data), 64'd0);
    tick(); tick();
    chk("fl_no_dead", 64'(s_out_valid), 64'd0);

    // reset in the middle of a full stage
    s_out_ready = 1'b0; s_in_valid = 1'b1; s_in_data = 32'h33;
    tick();
    s_in_data = 32'h44;
    tick();
    s_reset = 1'b1; s_in_data = 32'h55;
    tick();
    s_reset = 1'b0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    chk("mrst_occ", 64'(s_occ), 64'd0);
    chk("mrst_valid", 64'(s_out_valid), 64'd0);
    chk("mrst_ready", 64'(s_in_ready), 64'd1);
    tick(); tick();
    chk("mrst_no_stale", 64'(s_out_valid), 64'd0);

    // mixed traffic pattern
    k = 0;
    for (int i = 0; i < 24; i++) begin
      s_in_valid = (i % 3) != 2; s_out_ready = (i % 4) != 1;
      s_in_data = 32'h3000 + k; s_in_ctrl = 8'(k);
      @(negedge clk);
      fire = s_in_valid && s_in_ready;
      tick();
      if (fire) k++;
    end
    s_in_valid = 1'b0; s_out_ready = 1'b1;
    tick(); tick(); tick();

    exp_s = '{32'h1000, 32'h1004, 32'h1008, 32'hAAAA0001, 32'hBBBB0002};
    for (int j = 0; j < k; j++) exp_s.push_back(32'h3000 + j);
    chk("s_recv_count", 64'(recv_s.size()), 64'(exp_s.size()));
    for (int j = 0; j < exp_s.size() && j < recv_s.size(); j++)
      chk("s_recv_order", 64'(recv_s[j]), 64'(exp_s[j]));
    done_s = 1'b1;
  end

  // Single-entry instance: toggling backpressure, 16 entries
  initial begin
    int k;
    bit fire;
    tick();
    n_reset = 1'b0;
    chk("n_rst_ready", 64'(n_in_ready), 64'd1);
    chk("n_rst_valid", 64'(n_out_valid), 64'd0);
    k = 0;
    n_in_valid = 1'b1;
    for (int i = 0; i < 100 && k < 16; i++) begin
      n_out_ready = (i % 2) == 0;
      n_in_data = 32'h2000 + k; n_in_ctrl = 8'h80 | 8'(k);
      @(negedge clk);
      fire = n_in_ready;
      tick();
      if (fire) k++;
    end
    chk("n_sent", 64'(k), 64'd16);
    n_in_valid = 1'b0; n_out_ready = 1'b1;
    tick(); tick();
    chk("n_occ_max1", 64'(n_occ), 64'd0);
    chk("n_recv_count", 64'(recv_n.size()), 64'd16);
    for (int j = 0; j < 16 && j < recv_n.size(); j++)
      chk("n_recv_order", 64'(recv_n[j]), 64'(32'h2000 + j));
    done_n = 1'b1;
  end

  initial begin
    int c;
    for (c = 0; c < 5000 && !(done_s && done_n); c++) @(posedge clk);
    if (!(done_s && done_n)) begin
      n_vec++; n_err++;
      $display("FAIL timeout: got done=%0d%0d, want 11", done_s, done_n);
    end
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
